adpcm_bus_demux: RTL and testbench

- Clocked demultiplexer and arbiter between the YM2610 ADPCM buses and the shared V-ROM 8-bit read path.
- Latches the multiplexed ADPCM-A (SDR*) and ADPCM-B (SDP*) byte addresses and keeps one auto-incrementing address counter per bus.
- Arbitrates reads onto a single 24-bit address, V_ADDR_1, which the game-select offset adder and byte-lane mux downstream consume.
- Returns the selected V-ROM byte to the requesting bus.

---
 rtl/adpcm_bus_demux_pkg.sv | 27 ++
 rtl/adpcm_bus_demux_if.sv | 46 ++++
 rtl/adpcm_addr_port.sv | 109 ++++++++++
 rtl/adpcm_bus_demux.sv | 169 ++++++++++++++++
 tb/tb_adpcm_bus_demux.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/adpcm_bus_demux_pkg.sv
// ---------------------------------------------------------------------------
// adpcm_bus_demux_pkg
// Shared types and defaults for the YM2610 ADPCM-A/B to V-ROM demultiplexer.
//   state_t        : arbiter FSM state (IDLE, R_WAIT, P_WAIT)
//   V_ADDR_W       : V-ROM byte address width
//   BYTE_W         : V-ROM data width
//   *_DEF          : default values for the top-level parameters
// ---------------------------------------------------------------------------
package adpcm_bus_demux_pkg;

  localparam int V_ADDR_W = 24;
  localparam int BYTE_W   = 8;

  localparam int RD_WAIT_DEF     = 3;
  localparam int SYNC_STAGES_DEF = 2;
  localparam logic [V_ADDR_W-1:0] P_OFFSET_DEF = 24'h800000;

  typedef logic [V_ADDR_W-1:0] vaddr_t;
  typedef logic [BYTE_W-1:0]   byte_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    R_WAIT = 2'd1,
    P_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/adpcm_bus_demux_if.sv
// ---------------------------------------------------------------------------
// adpcm_bus_demux_if
// Bundles the ADPCM-A (SDR*), ADPCM-B (SDP*) and V-ROM side signals.
//   master : the YM2610 / V-ROM side (drives strobes, buses, V_DATA_8, MODE)
//   slave  : the demultiplexer (drives V_ADDR_1 and the read-data returns)
// ---------------------------------------------------------------------------
interface adpcm_bus_demux_if;
  import adpcm_bus_demux_pkg::*;

  logic       MODE;
  // ADPCM-A
  logic       SDRMPX;
  logic       nSDROE;
  byte_t      SDRAD_I;
  logic [1:0] SDRA_L;
  logic [3:0] SDRA_U;
  byte_t      SDRAD_O;
  logic       SDRAD_OE;
  // ADPCM-B
  logic       SDPMPX;
  logic       nSDPOE;
  byte_t      SDPAD_I;
  logic [3:0] SDPA;
  byte_t      SDPAD_O;
  logic       SDPAD_OE;
  // V-ROM read path
  byte_t      V_DATA_8;
  vaddr_t     V_ADDR_1;

  modport master (
    output MODE,
    output SDRMPX, nSDROE, SDRAD_I, SDRA_L, SDRA_U,
    output SDPMPX, nSDPOE, SDPAD_I, SDPA,
    output V_DATA_8,
    input  V_ADDR_1, SDRAD_O, SDRAD_OE, SDPAD_O, SDPAD_OE
  );

  modport slave (
    input  MODE,
    input  SDRMPX, nSDROE, SDRAD_I, SDRA_L, SDRA_U,
    input  SDPMPX, nSDPOE, SDPAD_I, SDPA,
    input  V_DATA_8,
    output V_ADDR_1, SDRAD_O, SDRAD_OE, SDPAD_O, SDPAD_OE
  );

endinterface

// File: rtl/adpcm_addr_port.sv
// ---------------------------------------------------------------------------
// adpcm_addr_port
// One ADPCM bus front end: strobe synchronisers, two-phase address latch,
// post-read auto-increment and the read-request flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   mpx        : address-phase strobe (high = phase 1, falling = phase 2)
//   oe_n       : read strobe, active-low
//   bus        : raw address bits; phase 1 uses bus[LO_W-1:0], phase 2 uses
//                all of bus for addr[23:LO_W]
//   grant      : arbiter has accepted this port's pending request
//   addr       : current byte address of this bus
//   req        : read request pending
//   rd         : synchronised read strobe, active-high
// ---------------------------------------------------------------------------
module adpcm_addr_port
  import adpcm_bus_demux_pkg::*;
#(
  parameter int LO_W        = 10,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mpx,
  input  logic                     oe_n,
  input  logic [V_ADDR_W-LO_W-1:0] bus,
  input  logic                     grant,
  output vaddr_t                   addr,
  output logic                     req,
  output logic                     rd
);

  localparam int BUS_W = V_ADDR_W - LO_W;

  // The read strobe is stored inverted so that cleared synchroniser flops
  // read as "no read in progress" and reset creates no spurious edge.
  logic [SYNC_STAGES-1:0]            mpx_sync;
  logic [SYNC_STAGES-1:0]            rd_sync;
  logic [SYNC_STAGES-1:0][BUS_W-1:0] bus_sync;
  logic                              mpx_prev;
  logic                              rd_prev;

  logic             mpx_s;
  logic             rd_s;
  logic [BUS_W-1:0] bus_s;
  logic             mpx_rise;
  logic             mpx_fall;
  logic             rd_rise;
  logic             rd_fall;

  // The address bus travels down the same number of stages as the strobes so
  // the value used at a synchronised edge is the one sampled with that edge.
  // NOTE: the bus pipeline is a register stage, not a memory, so it is reset
  // like every other flop; nothing here relies on uninitialised state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mpx_sync <= '0;
      rd_sync  <= '0;
      bus_sync <= '0;
      mpx_prev <= 1'b0;
      rd_prev  <= 1'b0;
    end else begin
      mpx_sync[0] <= mpx;
      rd_sync[0]  <= ~oe_n;
      bus_sync[0] <= bus;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mpx_sync[i] <= mpx_sync[i-1];
        rd_sync[i]  <= rd_sync[i-1];
        bus_sync[i] <= bus_sync[i-1];
      end
      mpx_prev <= mpx_s;
      rd_prev  <= rd_s;
    end
  end

  assign mpx_s    = mpx_sync[SYNC_STAGES-1];
  assign rd_s     = rd_sync[SYNC_STAGES-1];
  assign bus_s    = bus_sync[SYNC_STAGES-1];
  assign mpx_rise =  mpx_s & ~mpx_prev;
  assign mpx_fall = ~mpx_s &  mpx_prev;
  assign rd_rise  =  rd_s  & ~rd_prev;   // oe_n falling: read starts
  assign rd_fall  = ~rd_s  &  rd_prev;   // oe_n rising: read ends

  // Latch beats increment: a new address load discards the post-read +1.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (mpx_rise) begin
      addr[LO_W-1:0] <= bus_s[LO_W-1:0];
    end else if (mpx_fall) begin
      addr[V_ADDR_W-1:LO_W] <= bus_s;
    end else if (rd_fall) begin
      addr <= addr + vaddr_t'(1);
    end
  end

  // A new read start wins over a simultaneous grant of the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req <= 1'b0;
    end else begin
      req <= rd_rise | (req & ~grant);
    end
  end

  assign rd = rd_s;

endmodule

// File: rtl/adpcm_bus_demux.sv
// ---------------------------------------------------------------------------
// adpcm_bus_demux
// Demultiplexes the YM2610 ADPCM-A and ADPCM-B buses onto one V-ROM byte
// address and returns the fetched byte to the requesting bus. ADPCM-A has
// priority; each access holds the address for RD_WAIT clocks, then samples
// V_DATA_8.
//   CLK_68KCLKB : system clock, rising edge
//   nRESET      : asynchronous active-low reset
//   bus         : adpcm_bus_demux_if.slave (strobes, address/data buses,
//                 MODE, V_DATA_8 in; V_ADDR_1, SDRAD_O/OE, SDPAD_O/OE out)
// ---------------------------------------------------------------------------
module adpcm_bus_demux
  import adpcm_bus_demux_pkg::*;
#(
  parameter int     RD_WAIT     = RD_WAIT_DEF,
  parameter vaddr_t P_OFFSET    = P_OFFSET_DEF,
  parameter int     SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               CLK_68KCLKB,
  input  logic               nRESET,
  adpcm_bus_demux_if.slave   bus
);

  localparam int CNT_W = $clog2(RD_WAIT + 1);

  vaddr_t addr_r;
  vaddr_t addr_p;
  logic   req_r;
  logic   req_p;
  logic   rd_r;
  logic   rd_p;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_r;
  logic             grant_p;
  logic             done_r;
  logic             done_p;

  vaddr_t v_addr;
  byte_t  r_data;
  byte_t  p_data;
  logic   r_oe;
  logic   p_oe;

  // ADPCM-A: phase 1 = {A9:8, A7:0}, phase 2 = {A23:20, A19:18, A17:10}.
  adpcm_addr_port #(
    .LO_W        (10),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_port_r (
    .clk   (CLK_68KCLKB),
    .rst_n (nRESET),
    .mpx   (bus.SDRMPX),
    .oe_n  (bus.nSDROE),
    .bus   ({bus.SDRA_U, bus.SDRA_L, bus.SDRAD_I}),
    .grant (grant_r),
    .addr  (addr_r),
    .req   (req_r),
    .rd    (rd_r)
  );

  // ADPCM-B: phase 1 = {A11:8, A7:0}, phase 2 = {A23:20, A19:12}.
  adpcm_addr_port #(
    .LO_W        (12),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_port_p (
    .clk   (CLK_68KCLKB),
    .rst_n (nRESET),
    .mpx   (bus.SDPMPX),
    .oe_n  (bus.nSDPOE),
    .bus   ({bus.SDPA, bus.SDPAD_I}),
    .grant (grant_p),
    .addr  (addr_p),
    .req   (req_p),
    .rd    (rd_p)
  );

  always_ff @(posedge CLK_68KCLKB or negedge nRESET) begin
    if (!nRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    grant_r   = 1'b0;
    grant_p   = 1'b0;
    done_r    = 1'b0;
    done_p    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_r) begin
          grant_r   = 1'b1;
          state_nxt = R_WAIT;
        end else if (req_p) begin
          grant_p   = 1'b1;
          state_nxt = P_WAIT;
        end
      end
      R_WAIT: begin
        if (wait_cnt == CNT_W'(RD_WAIT - 1)) begin
          done_r    = 1'b1;
          state_nxt = IDLE;
        end
      end
      P_WAIT: begin
        if (wait_cnt == CNT_W'(RD_WAIT - 1)) begin
          done_p    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_68KCLKB or negedge nRESET) begin
    if (!nRESET) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // The address is captured at grant time; later MPX loads only affect the
  // next access. It holds its value while idle.
  always_ff @(posedge CLK_68KCLKB or negedge nRESET) begin
    if (!nRESET) begin
      v_addr <= '0;
    end else if (grant_r) begin
      v_addr <= addr_r;
    end else if (grant_p) begin
      v_addr <= addr_p + (bus.MODE ? P_OFFSET : '0);
    end
  end

  // Data is kept only if the requester is still strobing when it arrives;
  // otherwise the byte is dropped and the drive enable never rises.
  always_ff @(posedge CLK_68KCLKB or negedge nRESET) begin
    if (!nRESET) begin
      r_data <= '0;
      p_data <= '0;
      r_oe   <= 1'b0;
      p_oe   <= 1'b0;
    end else begin
      if (done_r && rd_r) begin
        r_data <= bus.V_DATA_8;
      end
      if (done_p && rd_p) begin
        p_data <= bus.V_DATA_8;
      end
      r_oe <= done_r ? rd_r : (r_oe & rd_r);
      p_oe <= done_p ? rd_p : (p_oe & rd_p);
    end
  end

  assign bus.V_ADDR_1 = v_addr;
  assign bus.SDRAD_O  = r_data;
  assign bus.SDRAD_OE = r_oe;
  assign bus.SDPAD_O  = p_data;
  assign bus.SDPAD_OE = p_oe;

endmodule

// File: tb/tb_adpcm_bus_demux.sv
// ---------------------------------------------------------------------------
// tb_adpcm_bus_demux
// Directed bench for adpcm_bus_demux with default parameters
// (RD_WAIT=3, SYNC_STAGES=2, P_OFFSET=24'h800000).
// Timing used throughout (inputs change 1 time unit after a rising edge):
//   read strobe falls -> V_ADDR_1 valid after the 4th rising edge
//   -> data/OE after 3 more edges; strobe rises -> OE low after 3 edges.
// ---------------------------------------------------------------------------
module tb_adpcm_bus_demux;
  import adpcm_bus_demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  adpcm_bus_demux_if bus ();

  adpcm_bus_demux dut (
    .CLK_68KCLKB (clk),
    .nRESET      (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_a(input byte_t ad1, input logic [1:0] l1,
                        input byte_t ad2, input logic [1:0] l2,
                        input logic [3:0] u);
    bus.SDRAD_I = ad1; bus.SDRA_L = l1; bus.SDRMPX = 1'b1;
    tick(4);
    bus.SDRAD_I = ad2; bus.SDRA_L = l2; bus.SDRA_U = u; bus.SDRMPX = 1'b0;
    tick(4);
  endtask

  task automatic load_b(input byte_t ad1, input logic [3:0] a1,
                        input byte_t ad2, input logic [3:0] a2);
    bus.SDPAD_I = ad1; bus.SDPA = a1; bus.SDPMPX = 1'b1;
    tick(4);
    bus.SDPAD_I = ad2; bus.SDPA = a2; bus.SDPMPX = 1'b0;
    tick(4);
  endtask

  task automatic test_reset;
    checks++; if (bus.V_ADDR_1 !== 24'h0) begin failures++; $display("FAIL rst_vaddr: got %h want 000000", bus.V_ADDR_1); end
    checks++; if (bus.SDRAD_O !== 8'h0 || bus.SDRAD_OE !== 1'b0) begin failures++; $display("FAIL rst_r: got %h/%b want 00/0", bus.SDRAD_O, bus.SDRAD_OE); end
    checks++; if (bus.SDPAD_O !== 8'h0 || bus.SDPAD_OE !== 1'b0) begin failures++; $display("FAIL rst_p: got %h/%b want 00/0", bus.SDPAD_O, bus.SDPAD_OE); end
  endtask

  // RA[9:0] = {01, 34}; RA[23:10] = {0111, 10, 01010110} -> RA = 0x795934.
  task automatic test_a_read;
    load_a(8'h34, 2'b01, 8'h56, 2'b10, 4'h7);
    bus.V_DATA_8 = 8'hA5; bus.nSDROE = 1'b0;
    tick(3);
    checks++; if (bus.V_ADDR_1 === 24'h795934) begin failures++; $display("FAIL a_addr_early: got %h before grant", bus.V_ADDR_1); end
    tick(1);
    checks++; if (bus.V_ADDR_1 !== 24'h795934) begin failures++; $display("FAIL a_addr: got %h want 795934", bus.V_ADDR_1); end
    tick(2);
    checks++; if (bus.SDRAD_OE !== 1'b0) begin failures++; $display("FAIL a_oe_early: got %b want 0", bus.SDRAD_OE); end
    tick(1);
    checks++; if (bus.SDRAD_O !== 8'hA5) begin failures++; $display("FAIL a_data: got %h want a5", bus.SDRAD_O); end
    checks++; if (bus.SDRAD_OE !== 1'b1) begin failures++; $display("FAIL a_oe: got %b want 1", bus.SDRAD_OE); end
    checks++; if (bus.SDPAD_OE !== 1'b0) begin failures++; $display("FAIL a_p_oe: got %b want 0", bus.SDPAD_OE); end
    tick(2);
    bus.nSDROE = 1'b1;
    tick(2);
    checks++; if (bus.SDRAD_OE !== 1'b1) begin failures++; $display("FAIL a_oe_hold: got %b want 1", bus.SDRAD_OE); end
    tick(1);
    checks++; if (bus.SDRAD_OE !== 1'b0) begin failures++; $display("FAIL a_oe_off: got %b want 0", bus.SDRAD_OE); end
    checks++; if (bus.V_ADDR_1 !== 24'h795934) begin failures++; $display("FAIL a_addr_hold: got %h want 795934", bus.V_ADDR_1); end
    tick(2);
    // Second read shows the post-read increment.
    bus.V_DATA_8 = 8'h3C; bus.nSDROE = 1'b0;
    tick(4);
    checks++; if (bus.V_ADDR_1 !== 24'h795935) begin failures++; $display("FAIL a_incr: got %h want 795935", bus.V_ADDR_1); end
    tick(3);
    checks++; if (bus.SDRAD_O !== 8'h3C) begin failures++; $display("FAIL a_data2: got %h want 3c", bus.SDRAD_O); end
    bus.nSDROE = 1'b1;
    tick(5);
  endtask

  task automatic test_wrap;
    load_a(8'hFF, 2'b11, 8'hFF, 2'b11, 4'hF);
    bus.V_DATA_8 = 8'h81; bus.nSDROE = 1'b0;
    tick(4);
    checks++; if (bus.V_ADDR_1 !== 24'hFFFFFF) begin failures++; $display("FAIL wrap_max: got %h want ffffff", bus.V_ADDR_1); end
    tick(3);
    bus.nSDROE = 1'b1;
    tick(5);
    bus.V_DATA_8 = 8'h82; bus.nSDROE = 1'b0;
    tick(4);
    checks++; if (bus.V_ADDR_1 !== 24'h000000) begin failures++; $display("FAIL wrap_zero: got %h want 000000", bus.V_ADDR_1); end
    tick(3);
    checks++; if (bus.SDRAD_O !== 8'h82) begin failures++; $display("FAIL wrap_data: got %h want 82", bus.SDRAD_O); end
    bus.nSDROE = 1'b1;
    tick(5);
  endtask

  // PA = {0x123, 0x456}; MODE=1 adds 0x800000 -> 0x923456.
  task automatic test_b_mode1;
    load_b(8'h56, 4'h4, 8'h23, 4'h1);
    bus.MODE = 1'b1;
    bus.V_DATA_8 = 8'h9E; bus.nSDPOE = 1'b0;
    tick(4);
    checks++; if (bus.V_ADDR_1 !== 24'h923456) begin failures++; $display("FAIL b_addr: got %h want 923456", bus.V_ADDR_1); end
    tick(3);
    checks++; if (bus.SDPAD_O !== 8'h9E || bus.SDPAD_OE !== 1'b1) begin failures++; $display("FAIL b_data: got %h/%b want 9e/1", bus.SDPAD_O, bus.SDPAD_OE); end
    checks++; if (bus.SDRAD_OE !== 1'b0) begin failures++; $display("FAIL b_r_oe: got %b want 0", bus.SDRAD_OE); end
    bus.nSDPOE = 1'b1;
    tick(3);
    checks++; if (bus.SDPAD_OE !== 1'b0) begin failures++; $display("FAIL b_oe_off: got %b want 0", bus.SDPAD_OE); end
    bus.MODE = 1'b0;
    tick(2);
  endtask

  // RA = 0x108010, PA = 0x201BCD; both strobes fall together.
  task automatic test_back_to_back;
    load_a(8'h10, 2'b00, 8'h20, 2'b00, 4'h1);
    load_b(8'hCD, 4'hB, 8'h01, 4'h2);
    bus.V_DATA_8 = 8'h11; bus.nSDROE = 1'b0; bus.nSDPOE = 1'b0;
    tick(4);
    checks++; if (bus.V_ADDR_1 !== 24'h108010) begin failures++; $display("FAIL both_r_addr: got %h want 108010", bus.V_ADDR_1); end
    tick(3);
    checks++; if (bus.SDRAD_O !== 8'h11 || bus.SDRAD_OE !== 1'b1) begin failures++; $display("FAIL both_r_data: got %h/%b want 11/1", bus.SDRAD_O, bus.SDRAD_OE); end
    checks++; if (bus.V_ADDR_1 !== 24'h108010) begin failures++; $display("FAIL both_r_hold: got %h want 108010", bus.V_ADDR_1); end
    bus.V_DATA_8 = 8'h22;
    tick(1);
    checks++; if (bus.V_ADDR_1 !== 24'h201BCD) begin failures++; $display("FAIL both_p_addr: got %h want 201bcd", bus.V_ADDR_1); end
    tick(3);
    checks++; if (bus.SDPAD_O !== 8'h22 || bus.SDPAD_OE !== 1'b1) begin failures++; $display("FAIL both_p_data: got %h/%b want 22/1", bus.SDPAD_O, bus.SDPAD_OE); end
    checks++; if (bus.SDRAD_O !== 8'h11) begin failures++; $display("FAIL both_r_keep: got %h want 11", bus.SDRAD_O); end
    bus.nSDROE = 1'b1; bus.nSDPOE = 1'b1;
    tick(5);
  endtask

  // RA is 0x108011 after the previous read; a one-clock pulse still fetches
  // from there, drops the data and bumps RA to 0x108012.
  task automatic test_abort;
    bus.V_DATA_8 = 8'h77; bus.nSDROE = 1'b0;
    tick(1);
    bus.nSDROE = 1'b1;
    for (int i = 2; i <= 10; i++) begin
      tick(1);
      if (i == 4) begin
        checks++; if (bus.V_ADDR_1 !== 24'h108011) begin failures++; $display("FAIL abort_addr: got %h want 108011", bus.V_ADDR_1); end
      end
      checks++; if (bus.SDRAD_OE !== 1'b0) begin failures++; $display("FAIL abort_oe: got %b want 0 at edge %0d", bus.SDRAD_OE, i); end
    end
    checks++; if (bus.SDRAD_O !== 8'h11) begin failures++; $display("FAIL abort_data: got %h want 11", bus.SDRAD_O); end
    bus.V_DATA_8 = 8'h5A; bus.nSDROE = 1'b0;
    tick(4);
    checks++; if (bus.V_ADDR_1 !== 24'h108012) begin failures++; $display("FAIL abort_incr: got %h want 108012", bus.V_ADDR_1); end
    tick(3);
    checks++; if (bus.SDRAD_O !== 8'h5A) begin failures++; $display("FAIL abort_next: got %h want 5a", bus.SDRAD_O); end
    bus.nSDROE = 1'b1;
    tick(5);
  endtask

  task automatic test_reset_mid;
    bus.V_DATA_8 = 8'h44; bus.nSDROE = 1'b0;
    tick(7);
    checks++; if (bus.SDRAD_OE !== 1'b1) begin failures++; $display("FAIL mid_pre_oe: got %b want 1", bus.SDRAD_OE); end
    bus.nSDPOE = 1'b0;
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.V_ADDR_1 !== 24'h0) begin failures++; $display("FAIL mid_vaddr: got %h want 000000", bus.V_ADDR_1); end
    checks++; if (bus.SDRAD_OE !== 1'b0 || bus.SDPAD_OE !== 1'b0) begin failures++; $display("FAIL mid_oe: got %b/%b want 0/0", bus.SDRAD_OE, bus.SDPAD_OE); end
    checks++; if (bus.SDRAD_O !== 8'h0 || bus.SDPAD_O !== 8'h0) begin failures++; $display("FAIL mid_data: got %h/%h want 00/00", bus.SDRAD_O, bus.SDPAD_O); end
    bus.nSDROE = 1'b1; bus.nSDPOE = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    checks++; if (bus.V_ADDR_1 !== 24'h0 || bus.SDPAD_OE !== 1'b0) begin failures++; $display("FAIL mid_lost: got %h/%b want 000000/0", bus.V_ADDR_1, bus.SDPAD_OE); end
    load_a(8'h34, 2'b01, 8'h56, 2'b10, 4'h7);
    bus.V_DATA_8 = 8'hC3; bus.nSDROE = 1'b0;
    tick(4);
    checks++; if (bus.V_ADDR_1 !== 24'h795934) begin failures++; $display("FAIL mid_addr: got %h want 795934", bus.V_ADDR_1); end
    tick(3);
    checks++; if (bus.SDRAD_O !== 8'hC3 || bus.SDRAD_OE !== 1'b1) begin failures++; $display("FAIL mid_read: got %h/%b want c3/1", bus.SDRAD_O, bus.SDRAD_OE); end
    bus.nSDROE = 1'b1;
    tick(5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    bus.MODE     = 1'b0;
    bus.SDRMPX   = 1'b0; bus.nSDROE = 1'b1; bus.SDRAD_I = '0; bus.SDRA_L = '0; bus.SDRA_U = '0;
    bus.SDPMPX   = 1'b0; bus.nSDPOE = 1'b1; bus.SDPAD_I = '0; bus.SDPA = '0;
    bus.V_DATA_8 = '0;
    tick(3);
    test_reset();
    rst_n = 1'b1;
    tick(3);
    test_a_read();
    test_wrap();
    test_b_mode1();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
